// File: rtl/rd_arb_sched.sv
// rd_arb_sched: round-robin arbiter sharing one wait-stated read port.
// Ports: clk, rst (async active-low), req[NREQ], ws in; gnt, cur_id, rd, ds, err, busy out.
module rd_arb_sched #(
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int TO_W   = 4,
    parameter int TO_MAX = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            ws,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  cur_id,
    output logic            rd,
    output logic            ds,
    output logic            err,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DLY  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] wcnt_q, wcnt_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  cur_id_q, cur_id_d;
    logic            err_q, err_d;

    logic            found;
    logic [IDW-1:0]  win;

    // Scan upward from the requester after the last one served, wrapping,
    // so the most recently served requester ends up with lowest priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            logic [IDW-1:0] idx;
            idx = IDW'((int'(last_q) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        last_d   = last_q;
        cur_id_d = cur_id_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    cur_id_d = win;
                    wcnt_d   = '0;
                    err_d    = 1'b0;
                    state_d  = READ;
                end
            end
            READ: state_d = DLY;
            DLY: begin
                if (!ws) begin
                    state_d = DONE;
                end else if (wcnt_q == TO_W'(TO_MAX - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            DONE: begin
                last_d  = cur_id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            last_q   <= IDW'(NREQ - 1);
            cur_id_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            last_q   <= last_d;
            cur_id_q <= cur_id_d;
            err_q    <= err_d;
        end
    end

    // Outputs come only from registered state, so an async reset drops
    // them immediately and no input reaches an output combinationally.
    assign busy   = (state_q != IDLE);
    assign gnt    = busy ? (NREQ'(1) << cur_id_q) : '0;
    assign cur_id = cur_id_q;
    assign rd     = (state_q == READ) || (state_q == DLY);
    assign ds     = (state_q == DONE);
    assign err    = (state_q == DONE) && err_q;

endmodule
